// File: rtl/switch_allocator_pkg.sv
// Shared NoC router parameters and types for the switch allocator slice.
// Port indices are the numeric values of port_t.
package switch_allocator_pkg;

    localparam int PORT_NUM    = 5;
    localparam int VC_NUM      = 2;
    localparam int VC_SIZE     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int PORT_W      = $clog2(PORT_NUM);
    localparam int BUFFER_SIZE = 8;

    typedef enum logic [PORT_W-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant/crossbar bundle between input VCs and the switch allocator.
// SA_PERF_COUNTERS_EN adds the per-output grant and stall counters.
interface switch_allocator_if;
    import switch_allocator_pkg::*;

    logic  [PORT_NUM-1:0][VC_NUM-1:0]              sa_request;
    port_t [PORT_NUM-1:0][VC_NUM-1:0]              out_port;
    logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              credit_return;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              sa_grant;
    logic  [PORT_NUM-1:0][PORT_W-1:0]              xb_sel;
    logic  [PORT_NUM-1:0]                          xb_valid;
    logic                                          credit_overflow;
`ifdef SA_PERF_COUNTERS_EN
    logic  [PORT_NUM-1:0][15:0]                    grant_count;
    logic  [PORT_NUM-1:0][15:0]                    stall_count;
`endif

    modport master (
        output sa_request, out_port, downstream_vc, credit_return,
        input  sa_grant, xb_sel, xb_valid, credit_overflow
`ifdef SA_PERF_COUNTERS_EN
        , input grant_count, stall_count
`endif
    );

    modport slave (
        input  sa_request, out_port, downstream_vc, credit_return,
        output sa_grant, xb_sel, xb_valid, credit_overflow
`ifdef SA_PERF_COUNTERS_EN
        , output grant_count, stall_count
`endif
    );

endinterface

// File: rtl/switch_allocator_round_robin_arbiter.sv
// Round-robin arbiter with one-hot grant; the search starts at the stored
// pointer, which moves past the winner only when update_en confirms the grant.
module round_robin_arbiter #(
    parameter int AGENTS_NUM = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AGENTS_NUM-1:0] request,
    input  logic                  update_en,
    output logic [AGENTS_NUM-1:0] grant
);

    localparam int PTR_W = (AGENTS_NUM > 1) ? $clog2(AGENTS_NUM) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] idx;
    logic             found;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        next_ptr = ptr;
        idx      = '0;
        for (int k = 0; k < AGENTS_NUM; k++) begin
            idx = PTR_W'((int'(ptr) + k) % AGENTS_NUM);
            if (!found && request[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                next_ptr   = PTR_W'((int'(idx) + 1) % AGENTS_NUM);
            end
        end
    end

    // NOTE: registered state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (update_en && found) begin
            ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Credit-aware separable input-first switch allocator (stage 1: VC per input,
// stage 2: input per output). SA_PERF_COUNTERS_EN enables grant/stall counters.
module switch_allocator #(
    parameter int BUFFER_SIZE = switch_allocator_pkg::BUFFER_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    switch_allocator_if.slave sa
);
    import switch_allocator_pkg::*;

    localparam int             CW   = $clog2(BUFFER_SIZE + 1);
    localparam logic [CW-1:0]  FULL = CW'(BUFFER_SIZE);

    logic [CW-1:0] credit [PORT_NUM][VC_NUM];
    logic          overflow;

    logic [PORT_NUM-1:0][VC_NUM-1:0]   eligible;
    logic [PORT_NUM-1:0][VC_NUM-1:0]   s1_grant;
    logic [PORT_NUM-1:0][VC_NUM-1:0]   grant;
    logic [PORT_NUM-1:0][VC_NUM-1:0]   consume;
    logic [PORT_NUM-1:0]               s1_valid;
    logic [PORT_NUM-1:0][PORT_W-1:0]   s1_port;
    logic [PORT_NUM-1:0][PORT_NUM-1:0] s2_req;
    logic [PORT_NUM-1:0][PORT_NUM-1:0] s2_grant;
    logic [PORT_NUM-1:0][PORT_W-1:0]   sel;
    logic [PORT_NUM-1:0]               valid;

    // Eligibility sees only the registered counters; same-cycle returns do not count.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (sa.sa_request[i][v] && int'(sa.out_port[i][v]) < PORT_NUM &&
                    credit[sa.out_port[i][v]][sa.downstream_vc[i][v]] != '0) begin
                    eligible[i][v] = 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < PORT_NUM; i++) begin : g_stage1
        round_robin_arbiter #(.AGENTS_NUM(VC_NUM)) u_arb (
            .clk      (clk),
            .rst      (rst),
            .request  (eligible[i]),
            .update_en(|grant[i]),
            .grant    (s1_grant[i])
        );
    end

    always_comb begin
        s1_valid = '0;
        s1_port  = '0;
        s2_req   = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (s1_grant[i][v]) begin
                    s1_valid[i] = 1'b1;
                    s1_port[i]  = sa.out_port[i][v];
                end
            end
            if (s1_valid[i]) s2_req[s1_port[i]][i] = 1'b1;
        end
    end

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_stage2
        round_robin_arbiter #(.AGENTS_NUM(PORT_NUM)) u_arb (
            .clk      (clk),
            .rst      (rst),
            .request  (s2_req[o]),
            .update_en(valid[o]),
            .grant    (s2_grant[o])
        );
    end

    // A stage-2 win confirms the input's stage-1 VC; at most one grant per counter.
    always_comb begin
        grant   = '0;
        sel     = '0;
        valid   = '0;
        consume = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                if (s2_grant[o][i]) begin
                    valid[o] = 1'b1;
                    sel[o]   = PORT_W'(i);
                    grant[i] = s1_grant[i];
                end
            end
        end
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (grant[i][v]) consume[sa.out_port[i][v]][sa.downstream_vc[i][v]] = 1'b1;
            end
        end
    end

    // NOTE: the credit array is reset explicitly; its reset value is the initial credit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < PORT_NUM; p++)
                for (int d = 0; d < VC_NUM; d++)
                    credit[p][d] <= FULL;
            overflow <= 1'b0;
        end else begin
            for (int p = 0; p < PORT_NUM; p++) begin
                for (int d = 0; d < VC_NUM; d++) begin
                    if (consume[p][d] && !sa.credit_return[p][d]) begin
                        credit[p][d] <= credit[p][d] - 1'b1;
                    end else if (!consume[p][d] && sa.credit_return[p][d]) begin
                        if (credit[p][d] == FULL) overflow <= 1'b1;
                        else credit[p][d] <= credit[p][d] + 1'b1;
                    end
                end
            end
        end
    end

    assign sa.sa_grant        = rst ? grant : '0;
    assign sa.xb_sel          = rst ? sel   : '0;
    assign sa.xb_valid        = rst ? valid : '0;
    assign sa.credit_overflow = overflow;

`ifdef SA_PERF_COUNTERS_EN
    logic [PORT_NUM-1:0]       starved;
    logic [PORT_NUM-1:0][15:0] grant_count;
    logic [PORT_NUM-1:0][15:0] stall_count;

    always_comb begin
        starved = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (sa.sa_request[i][v] && int'(sa.out_port[i][v]) < PORT_NUM &&
                    credit[sa.out_port[i][v]][sa.downstream_vc[i][v]] == '0) begin
                    starved[sa.out_port[i][v]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_count <= '0;
            stall_count <= '0;
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                if (valid[o] && grant_count[o] != 16'hFFFF) grant_count[o] <= grant_count[o] + 16'd1;
                if (starved[o] && stall_count[o] != 16'hFFFF) stall_count[o] <= stall_count[o] + 16'd1;
            end
        end
    end

    assign sa.grant_count = grant_count;
    assign sa.stall_count = stall_count;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboard bench for switch_allocator (BUFFER_SIZE=4): the driver queues the
// hand-computed response for each cycle, a negedge monitor pops and compares.
module tb_switch_allocator;
    import switch_allocator_pkg::*;

    localparam int W = PORT_NUM * VC_NUM + PORT_NUM * PORT_W + PORT_NUM + 1;

    typedef struct {
        string                           name;
        logic [PORT_NUM-1:0][VC_NUM-1:0] grant;
        logic [PORT_NUM-1:0][PORT_W-1:0] sel;
        logic [PORT_NUM-1:0]             valid;
        logic                            ovf;
    } exp_t;

    logic clk;
    logic rst;
    switch_allocator_if sa_if ();

    switch_allocator #(.BUFFER_SIZE(4)) dut (
        .clk(clk),
        .rst(rst),
        .sa (sa_if)
    );

    exp_t exp_q[$];
    int   tests;
    int   fails;
    logic cur_ovf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (grant|sel|valid|ovf)", nm, got, want);
        end
    endtask

    // Monitor: one comparison per queued cycle, sampled mid-cycle.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                check(x.name,
                      {sa_if.sa_grant, sa_if.xb_sel, sa_if.xb_valid, sa_if.credit_overflow},
                      {x.grant, x.sel, x.valid, x.ovf});
            end
        end
    end

    function automatic exp_t idle(input string nm);
        exp_t x;
        x.name  = nm;
        x.grant = '0;
        x.sel   = '0;
        x.valid = '0;
        x.ovf   = cur_ovf;
        return x;
    endfunction

    function automatic exp_t add_grant(input exp_t x, input int i, input int v, input int o);
        exp_t y = x;
        y.grant[i][v] = 1'b1;
        y.sel[o]      = PORT_W'(i);
        y.valid[o]    = 1'b1;
        return y;
    endfunction

    task automatic step(input exp_t x);
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        sa_if.sa_request    = '0;
        sa_if.downstream_vc = '0;
        sa_if.credit_return = '0;
        for (int i = 0; i < PORT_NUM; i++)
            for (int v = 0; v < VC_NUM; v++)
                sa_if.out_port[i][v] = LOCAL;
    endtask

    task automatic req(input int i, input int v, input int p, input int d);
        sa_if.sa_request[i][v]    = 1'b1;
        sa_if.out_port[i][v]      = port_t'(p);
        sa_if.downstream_vc[i][v] = VC_SIZE'(d);
    endtask

    // One cycle with rst low: outputs forced to zero, flag still shows its old value.
    task automatic do_reset(input string nm);
        rst = 1'b0;
        step(idle(nm));
        cur_ovf = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests   = 0;
        fails   = 0;
        cur_ovf = 1'b0;
        rst     = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;

        // Request present during reset must not show up on the outputs.
        req(0, 1, 2, 0);
        step(idle("reset_forces_zero"));
        rst = 1'b1;

        // Single requester drains 4 credits, then waits for a return.
        for (int c = 1; c <= 4; c++)
            step(add_grant(idle($sformatf("drain_c%0d", c)), 0, 1, 2));
        step(idle("empty_c5"));
        sa_if.credit_return[2][0] = 1'b1;
        step(idle("return_not_same_cycle_c6"));
        sa_if.credit_return[2][0] = 1'b0;
        step(add_grant(idle("refill_c7"), 0, 1, 2));
        sa_if.credit_return[2][0] = 1'b1;
        step(idle("empty_with_return"));
        step(add_grant(idle("grant_and_return"), 0, 1, 2));
        sa_if.credit_return[2][0] = 1'b0;
        step(add_grant(idle("counter_unchanged"), 0, 1, 2));
        step(idle("drained_again"));
        do_reset("reset_after_drain");
        clear_inputs();

        // Five inputs contend for output 4; returns keep the counter topped up.
        for (int i = 0; i < PORT_NUM; i++) req(i, 0, 4, 1);
        sa_if.credit_return[4][1] = 1'b1;
        for (int k = 0; k < 6; k++)
            step(add_grant(idle($sformatf("rr_out4_k%0d", k)), k % PORT_NUM, 0, 4));
        clear_inputs();
        do_reset("reset_after_rr_out");

        // Input 0 alternates its two VCs towards outputs 1 and 3.
        req(0, 0, 1, 0);
        req(0, 1, 3, 0);
        for (int k = 0; k < 4; k++)
            step(add_grant(idle($sformatf("rr_vc_k%0d", k)), 0, k % 2, (k % 2 == 1) ? 3 : 1));
        clear_inputs();
        do_reset("reset_after_rr_vc");

        // Stage-2 loser keeps its input pointer.
        req(0, 0, 1, 0);
        req(0, 1, 2, 0);
        req(1, 0, 1, 1);
        req(1, 1, 1, 0);
        step(add_grant(idle("s2_c1"), 0, 0, 1));
        step(add_grant(add_grant(idle("s2_c2"), 0, 1, 2), 1, 0, 1));
        step(add_grant(idle("s2_c3"), 0, 0, 1));
        step(add_grant(add_grant(idle("s2_c4"), 0, 1, 2), 1, 1, 1));
        clear_inputs();
        do_reset("reset_after_s2");

        // Return to a full counter: sticky flag, counter stays at 4.
        sa_if.credit_return[2][0] = 1'b1;
        step(idle("overflow_pulse"));
        sa_if.credit_return[2][0] = 1'b0;
        cur_ovf = 1'b1;
        step(idle("overflow_set"));
        req(0, 0, 2, 0);
        for (int c = 1; c <= 4; c++)
            step(add_grant(idle($sformatf("ovf_drain_c%0d", c)), 0, 0, 2));
        step(idle("ovf_no_extra_credit"));
        clear_inputs();
        do_reset("reset_clears_overflow");

        // Reset in the middle of traffic restores credits and pointers.
        req(0, 1, 2, 0);
        req(1, 0, 2, 0);
        step(add_grant(idle("mid_c1"), 0, 1, 2));
        step(add_grant(idle("mid_c2"), 1, 0, 2));
        step(add_grant(idle("mid_c3"), 0, 1, 2));
        do_reset("reset_midrun");
        step(add_grant(idle("post_c1"), 0, 1, 2));
        step(add_grant(idle("post_c2"), 1, 0, 2));
        step(add_grant(idle("post_c3"), 0, 1, 2));
        step(add_grant(idle("post_c4"), 1, 0, 2));
        step(idle("post_c5_empty"));
        clear_inputs();
        step(idle("final_idle"));

        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left in queue, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
